// File: rtl/food_spawner_if.sv
// food_spawner_if: spawn request/restart, snake-body read port and food position outputs
interface food_spawner_if;
  logic       add;
  logic       restart;
  logic [6:0] cubenum;
  logic [5:0] seg_idx;
  logic [5:0] seg_x;
  logic [5:0] seg_y;
  logic [5:0] foodx;
  logic [4:0] foody;
  logic       busy;
  logic       spawn_fail;
  modport master(output add, restart, cubenum, seg_x, seg_y,
                 input seg_idx, foodx, foody, busy, spawn_fail);
  modport slave(input add, restart, cubenum, seg_x, seg_y,
                output seg_idx, foodx, foody, busy, spawn_fail);
endinterface

// File: rtl/food_spawner.sv
// food_spawner: draws LFSR food candidates, rejects those on the snake body, publishes a free cell
module food_spawner #(
  parameter int          GRID_W    = 40,
  parameter int          GRID_H    = 30,
  parameter int          FOOD_X0   = 24,
  parameter int          FOOD_Y0   = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRY   = 15
) (
  input logic clk,
  input logic rst_n,
  food_spawner_if.slave bus
);
  localparam int TW = $clog2(MAX_TRY + 1);
  typedef enum logic [1:0] {IDLE, GEN, SCAN, PUB} state_t;
  state_t        state, state_d;
  logic [15:0]   lfsr;
  logic [5:0]    cx, lx;
  logic [4:0]    cy, ly;
  logic [6:0]    k, n;
  logic [TW-1:0] try_cnt;
  logic          in_range, hit, last;
  assign cx = lfsr[5:0];
  assign cy = lfsr[12:8];
  assign in_range = cx >= 6'd1 && cx <= 6'(GRID_W - 2) && cy >= 5'd1 && cy <= 5'(GRID_H - 2);
  // body data lags seg_idx by one cycle, so k=0 carries no valid segment
  assign hit = state == SCAN && k != 7'd0 && !bus.seg_y[5] && bus.seg_x == lx && bus.seg_y[4:0] == ly;
  assign last = k == n;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_d = state;
    if (bus.restart) state_d = IDLE;
    else if (state == IDLE) state_d = bus.add ? GEN : IDLE;
    else if (state == GEN) state_d = in_range ? SCAN : GEN;
    else if (state == SCAN) state_d = hit ? GEN : last ? PUB : SCAN;
    else state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr           <= LFSR_SEED;
      bus.foodx      <= 6'(FOOD_X0);
      bus.foody      <= 5'(FOOD_Y0);
      bus.spawn_fail <= 1'b0;
      bus.seg_idx    <= 6'd0;
      try_cnt        <= '0;
      lx             <= 6'd0;
      ly             <= 5'd0;
      k              <= 7'd0;
      n              <= 7'd1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (bus.restart) begin
        bus.foodx      <= 6'(FOOD_X0);
        bus.foody      <= 5'(FOOD_Y0);
        bus.spawn_fail <= 1'b0;
        try_cnt        <= '0;
      end else if (state == GEN && in_range) begin
        lx          <= cx;
        ly          <= cy;
        k           <= 7'd0;
        bus.seg_idx <= 6'd0;
        n           <= bus.cubenum == 7'd0 ? 7'd1 : bus.cubenum > 7'd64 ? 7'd64 : bus.cubenum;
      end else if (state == SCAN) begin
        k <= k + 7'd1;
        if (k + 7'd1 < n) bus.seg_idx <= 6'(k + 7'd1);
        if (hit) begin
          try_cnt <= try_cnt == TW'(MAX_TRY) ? try_cnt : try_cnt + 1'b1;
          if (try_cnt >= TW'(MAX_TRY - 1)) bus.spawn_fail <= 1'b1;
        end
      end else if (state == PUB) begin
        bus.foodx <= lx;
        bus.foody <= ly;
        try_cnt   <= '0;
      end
    end
endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: random spawns against a transaction-level model of candidate draws and body scans
module tb_food_spawner;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  food_spawner_if ifc();
  food_spawner dut(.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  logic [5:0] bx[64];
  logic [5:0] by[64];
  always @(posedge clk) begin
    ifc.seg_x <= bx[ifc.seg_idx];
    ifc.seg_y <= by[ifc.seg_idx];
  end
  int n_cmp = 0, n_bad = 0;
  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  function automatic int eff_n(input logic [6:0] c);
    return c == 7'd0 ? 1 : c > 7'd64 ? 64 : int'(c);
  endfunction
  function automatic int first_hit(input logic [5:0] x, input logic [4:0] y, input int n);
    for (int j = 0; j < n; j++) if (bx[j] == x && by[j] == {1'b0, y}) return j;
    return -1;
  endfunction
  function automatic int occupied(input logic [5:0] x, input logic [4:0] y, input int n);
    return first_hit(x, y, n) >= 0 ? 1 : 0;
  endfunction
  // Offsets count cycles from the first candidate cycle (the one after add).
  // A candidate at offset t rejected at segment j costs j+3 cycles; a free one publishes at t+n+3.
  function automatic void spawn_model(input logic [15:0] l0, input int n, output int lat,
                                      output int fail_at, output int rej,
                                      output logic [5:0] x, output logic [4:0] y);
    logic [15:0] l;
    int t, j;
    l = l0; t = 0; rej = 0; fail_at = -1; lat = -1; x = 0; y = 0;
    while (t < 50000) begin
      x = l[5:0];
      y = l[12:8];
      if (x < 1 || x > 38 || y < 1 || y > 28) begin
        l = step(l);
        t++;
      end else begin
        j = first_hit(x, y, n);
        if (j < 0) begin
          lat = t + n + 3;
          return;
        end
        for (int i = 0; i < j + 3; i++) l = step(l);
        t += j + 3;
        rej++;
        if (rej == 15) fail_at = t;
      end
    end
  endfunction
  logic [15:0] lf = SEED;
  logic m_busy = 1'b0, m_fail = 1'b0;
  logic [5:0] m_fx = 6'd24, r_x;
  logic [4:0] m_fy = 5'd10, r_y;
  int m_k = 0, m_lat = 0, m_fail_at = -1, m_rej = 0, m_n = 1, m_nprev = 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf = SEED; m_busy = 0; m_fail = 0; m_fx = 6'd24; m_fy = 5'd10;
    end else begin
      if (ifc.restart) begin
        m_busy = 0; m_fail = 0; m_fx = 6'd24; m_fy = 5'd10;
      end else if (m_busy) begin
        m_k++;
        if (m_k == m_fail_at) m_fail = 1;
        if (m_k == m_lat) begin
          m_busy = 0; m_fx = r_x; m_fy = r_y;
        end
      end else if (ifc.add) begin
        m_nprev = m_n;
        m_n = eff_n(ifc.cubenum);
        spawn_model(step(lf), m_n, m_lat, m_fail_at, m_rej, r_x, r_y);
        m_k = 0;
        m_busy = 1;
      end
      lf = step(lf);
    end
  end
  always @(negedge clk) begin
    chk("busy", ifc.busy, m_busy);
    chk("foodx", ifc.foodx, m_fx);
    chk("foody", ifc.foody, m_fy);
    chk("spawn_fail", ifc.spawn_fail, m_fail);
    if (m_busy) chk("seg_idx_bound", ifc.seg_idx < (m_n > m_nprev ? m_n : m_nprev), 1);
  end
  task automatic tick(input int c = 1);
    repeat (c) @(posedge clk);
    #1;
  endtask
  task automatic pulse_add();
    ifc.add = 1'b1; tick(); ifc.add = 1'b0;
  endtask
  task automatic wait_idle(input string nm, input bit noise);
    int c = 0;
    while ((m_busy || ifc.busy) && c < 3000) begin
      if (noise && $urandom_range(0, 19) == 0) ifc.add = 1'b1;
      tick();
      ifc.add = 1'b0;
      c++;
    end
    chk({nm, "_done"}, ifc.busy, 0);
  endtask
  task automatic chk_pub(input string nm, input int n);
    chk({nm, "_range"}, ifc.foodx >= 1 && ifc.foodx <= 38 && ifc.foody >= 1 && ifc.foody <= 28, 1);
    chk({nm, "_free"}, occupied(ifc.foodx, ifc.foody, n), 0);
  endtask
  task automatic rand_body();
    for (int i = 0; i < 64; i++) begin
      bx[i] = 6'($urandom_range(0, 39));
      by[i] = 6'($urandom_range(0, 29)) | ($urandom_range(0, 15) == 0 ? 6'd32 : 6'd0);
    end
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int bc, m, lat, fa, rej;
    logic [5:0] x;
    logic [4:0] y;
    ifc.add = 1'b0; ifc.restart = 1'b0; ifc.cubenum = 7'd3;
    for (int i = 0; i < 64; i++) begin bx[i] = 6'd0; by[i] = 6'd32; end
    tick(3);
    chk("rst_foodx", ifc.foodx, 24);
    chk("rst_foody", ifc.foody, 10);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_fail", ifc.spawn_fail, 0);
    chk("rst_seg_idx", ifc.seg_idx, 0);
    rst_n = 1'b1;
    tick(100);
    chk("idle_foodx", ifc.foodx, 24);
    chk("idle_foody", ifc.foody, 10);
    chk("idle_busy", ifc.busy, 0);
    bx[0] = 6'd5; by[0] = 6'd5; bx[1] = 6'd6; by[1] = 6'd5; bx[2] = 6'd7; by[2] = 6'd5;
    pulse_add();
    bc = 0;
    while (ifc.busy && bc < 3000) begin bc++; tick(); end
    chk("t2_busy_min", bc >= 6, 1);
    chk("t2_busy_len", bc, m_lat);
    chk("t2_busy_low", ifc.busy, 0);
    chk_pub("t2", 3);
    ifc.cubenum = 7'd64;
    for (int i = 0; i < 64; i++) begin bx[i] = 6'd0; by[i] = 6'd32; end
    m = 0;
    // plant each would-be free candidate into the body until 15 rejections are forced
    do begin
      spawn_model(step(lf), 64, lat, fa, rej, x, y);
      if (rej < 15) begin bx[m] = x; by[m] = {1'b0, y}; m++; end
    end while (rej < 15 && m < 64);
    chk("t3_fail_pre", ifc.spawn_fail, 0);
    pulse_add();
    wait_idle("t3", 1'b0);
    chk("t3_fail", ifc.spawn_fail, 1);
    chk_pub("t3", 64);
    tick(5);
    chk("t3_fail_sticky", ifc.spawn_fail, 1);
    pulse_add();
    tick(3);
    ifc.restart = 1'b1; tick(); ifc.restart = 1'b0;
    chk("t4_busy", ifc.busy, 0);
    chk("t4_foodx", ifc.foodx, 24);
    chk("t4_foody", ifc.foody, 10);
    chk("t4_fail_clr", ifc.spawn_fail, 0);
    tick(100);
    chk("t4_foodx_late", ifc.foodx, 24);
    chk("t4_foody_late", ifc.foody, 10);
    rand_body();
    pulse_add();
    wait_idle("t5_pre", 1'b0);
    ifc.restart = 1'b1; ifc.add = 1'b1; tick(); ifc.restart = 1'b0; ifc.add = 1'b0;
    chk("t5_busy", ifc.busy, 0);
    chk("t5_foodx", ifc.foodx, 24);
    chk("t5_foody", ifc.foody, 10);
    tick(10);
    chk("t5_busy_late", ifc.busy, 0);
    rand_body();
    pulse_add();
    wait_idle("ar_pre", 1'b0);
    pulse_add();
    tick(10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", ifc.busy, 0);
    chk("ar_foodx", ifc.foodx, 24);
    chk("ar_foody", ifc.foody, 10);
    chk("ar_seg_idx", ifc.seg_idx, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    for (int s = 0; s < 400; s++) begin
      ifc.cubenum = s < 60 ? 7'($urandom_range(0, 64)) : 7'd64;
      rand_body();
      tick($urandom_range(0, 3));
      pulse_add();
      wait_idle("t6", 1'b1);
      chk_pub("t6", eff_n(ifc.cubenum));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
